// File: rtl/hzdm.sv
// Register-hazard scoreboard and issue controller with fence/CSR drain.
// Optional stall-cycle counter port enabled by defining HZDM_PERF_CNT_EN.
module hzdm #(
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rs1_i,
  input  logic        issue_rs1_used_i,
  input  logic [4:0]  issue_rs2_i,
  input  logic        issue_rs2_used_i,
  input  logic        issue_reg_write_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        retire_valid_i,
  input  logic [4:0]  retire_rd_i,
  input  logic        cancel_valid_i,
  input  logic [4:0]  cancel_rd_i,
  input  logic        drain_req_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        drain_ack_o,
  output logic        err_o
`ifdef HZDM_PERF_CNT_EN
  ,
  output logic [31:0] stall_count_o
`endif
);

  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CntMax = CW'(MAX_INFLIGHT);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StDrain = 1'b1;

  // Entry 0 exists only so 5-bit indices stay in range; it is held at zero.
  logic [CW-1:0] cnt_q [32];
  logic [CW-1:0] cnt_d [32];
  logic [0:0]    state_q, state_d;
  logic          err_q, err_d;
  logic          hazard, issue_fire, underflow;

  always_comb begin
    hazard = 1'b0;
    if (issue_rs1_used_i && issue_rs1_i != 5'd0 && cnt_q[issue_rs1_i] != '0) hazard = 1'b1;
    if (issue_rs2_used_i && issue_rs2_i != 5'd0 && cnt_q[issue_rs2_i] != '0) hazard = 1'b1;
    if (issue_reg_write_i && issue_rd_i != 5'd0 && cnt_q[issue_rd_i] == CntMax) hazard = 1'b1;
  end

  assign stall_o     = (state_q == StDrain) ? 1'b1 : hazard;
  assign issue_fire  = issue_valid_i & ~stall_o & issue_reg_write_i & (issue_rd_i != 5'd0);
  assign drain_ack_o = (state_q == StDrain) & ~busy_o;
  assign err_o       = err_q;

  always_comb begin
    busy_o = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (cnt_q[r] != '0) busy_o = 1'b1;
    end
  end

  // All same-cycle updates combine into one net change; going below zero saturates.
  always_comb begin
    logic [CW:0] sum;
    logic [1:0]  dec;
    sum       = '0;
    dec       = '0;
    underflow = 1'b0;
    cnt_d[0]  = '0;
    for (int r = 1; r < 32; r++) begin
      sum = {1'b0, cnt_q[r]} + (CW+1)'(issue_fire && issue_rd_i == 5'(r));
      dec = {1'b0, retire_valid_i && retire_rd_i == 5'(r)}
          + {1'b0, cancel_valid_i && cancel_rd_i == 5'(r)};
      if (sum < (CW+1)'(dec)) begin
        cnt_d[r]  = '0;
        underflow = 1'b1;
      end else begin
        cnt_d[r] = CW'(sum - (CW+1)'(dec));
      end
    end
  end

  assign err_d = err_q | underflow;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (drain_req_i) state_d = StDrain;
      StDrain: if (!busy_o) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

`ifdef HZDM_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
    end else if (issue_valid_i && stall_o) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: doc/hzdm.md
# hzdm

Register-hazard scoreboard and issue controller for the decode stage. It counts the in-flight register writes per architectural register and holds decode with `stall_o` when a source operand or destination has an unresolved write. It also performs pipeline drains for fences and CSR accesses. It sits beside `decm`: decode reports each accepted instruction, and writeback and squash logic report completions.

## Interface
- `MAX_INFLIGHT`, default 3: maximum outstanding writes tracked per register. Counter width is CW = $clog2(MAX_INFLIGHT+1).
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset. Asynchronous, active-high.
- `issue_valid_i` in 1: decode accepts an instruction this cycle. It counts only when `stall_o`=0.
- `issue_rs1_i` in 5: source register 1. `issue_rs1_used_i` in 1: rs1 is read.
- `issue_rs2_i` in 5: source register 2. `issue_rs2_used_i` in 1: rs2 is read.
- `issue_reg_write_i` in 1: the instruction writes rd. `issue_rd_i` in 5: destination register.
- `retire_valid_i` in 1 and `retire_rd_i` in 5: writeback commits a write to rd this cycle.
- `cancel_valid_i` in 1 and `cancel_rd_i` in 5: a squashed instruction with a pending write to rd is dropped.
- `drain_req_i` in 1: request to empty all pending writes (fence/CSR).
- `stall_o` out 1: decode must not issue.
- `busy_o` out 1: at least one counter is non-zero.
- `drain_ack_o` out 1: one-cycle pulse when the drain completes.
- `err_o` out 1: sticky protocol error.
- `stall_count_o` out 32: stall-cycle count. Present only with `HZDM_PERF_CNT_EN`.

## Operation
- **Scoreboard.** 31 CW-bit counters `cnt[1..31]`. Register x0 is never tracked: any issue, retire or cancel with rd=0 is ignored, and x0 is never a hazard.
- **Increment.** `issue_valid_i & !stall_o & issue_reg_write_i & rd!=0` increments `cnt[rd]` by 1.
- **Decrement.** `retire_valid_i` decrements `cnt[retire_rd]` by 1, and `cancel_valid_i` decrements `cnt[cancel_rd]` by 1.
- **Same-cycle updates.**
  - All updates in one cycle apply together; the net change per register ranges from -2 to +1.
  - Issue and retire to the same rd in one cycle leave the count unchanged.
- **Underflow.** A decrement of a zero counter saturates at 0 and sets `err_o`. `err_o` clears only on reset.
- **Hazard term.** `stall_o` is asserted when any of the following hold (this is not the full equation; see the FSM):
  - `issue_rs1_used_i & rs1!=0 & cnt[rs1]!=0`
  - `issue_rs2_used_i & rs2!=0 & cnt[rs2]!=0`
  - `issue_reg_write_i & rd!=0 & cnt[rd]==MAX_INFLIGHT`
- **State machine** (2 states):
  - IDLE: `stall_o` = hazard term. When `drain_req_i` is sampled at 1, the next state is DRAIN.
  - DRAIN: `stall_o`=1 unconditionally. When all counters are 0 (`busy_o`=0), `drain_ack_o` pulses and the next state is IDLE.
  - A drain request while already in DRAIN is ignored.
  - If the scoreboard is already empty on entry, the ack occurs on the first DRAIN cycle.
- **Issue while stalled.** `issue_valid_i` asserted while `stall_o`=1 is not counted and is not an error. Decode holds the instruction.

## Timing
- `stall_o` is combinational from the issue inputs, the registered counters and the state. It uses no same-cycle bypass from retire, because the register file write lands at the clock edge.
- Counter updates take effect on the rising edge. An operand whose write retires in cycle N is issuable in cycle N+1.
- `busy_o` and `drain_ack_o` are registered-state derived: `drain_ack_o` is high during the cycle the FSM is in DRAIN with all counters at 0.
- A drain sampled in cycle N forces `stall_o`=1 from cycle N+1.
- Reset values:
  - all counters 0 and state IDLE
  - `stall_o` = hazard term only (0 with idle inputs)
  - `busy_o`=0, `drain_ack_o`=0, `err_o`=0, `stall_count_o`=0
- Reset mid-drain returns to IDLE with no ack.

## Configuration
- `HZDM_PERF_CNT_EN` defined:
  - `stall_count_o` increments each cycle in which `issue_valid_i & stall_o`.
  - It wraps from 0xFFFFFFFF to 0 and resets to 0.
- `HZDM_PERF_CNT_EN` undefined: the port and the counter are absent, and the behaviour is otherwise identical.

## Test plan
- **RAW hazard.** Issue a write to x5 in cycle 0. In cycle 1, issue with rs1=x5 → `stall_o`=1. Retire x5 in cycle 3 → `stall_o`=0 in cycle 4, and the issue is counted.
- **x0 and unused sources.** Issue with rd=x0, then rs1=x0 → no stall and `busy_o`=0. With rs2=x7 pending and `issue_rs2_used_i`=0 → no stall.
- **Saturation.** With MAX_INFLIGHT=3, three issues to x9 give cnt=3, and a fourth write to x9 stalls. Simultaneous issue and retire on x9 at cnt=2 keep cnt=2.
- **Cancel and error.** Issue to x3, then cancel x3 together with a retire of x4 at cnt[x4]=0 → cnt[x3]=0 and `err_o`=1 sticky.
- **Drain.** With two pending writes, assert `drain_req_i` → `stall_o`=1 throughout. After the second retire, `drain_ack_o` pulses for exactly one cycle and the FSM returns to IDLE. Asserting reset mid-drain gives no ack.
- **Perf counter** (`HZDM_PERF_CNT_EN`): four stalled issue cycles → `stall_count_o`=4. Stalled cycles without `issue_valid_i` are not counted.
